// File: rtl/header_adder_var.sv
// header_adder_var
//   Prepends a per-packet header of 0..HDR_BYTES bytes to an AXI-Stream
//   packet. Each packet waits for a descriptor (header, header_len, drop);
//   the descriptor either supplies the header bytes or discards the packet.
//   The data path is combinational; the only added latency is the extra
//   trailing word emitted when the header pushes bytes past the input tlast
//   word.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 input stream (tkeep contiguous, low aligned)
//   header, header_len       header bytes (byte 0 = header[7:0]) and length
//   drop                     discard the packet instead of forwarding it
//   header_valid/ready       descriptor handshake, one per packet
//   m_axis_*                 output stream
//
// state | meaning
// IDLE  | waiting for descriptor + first word; first word merges header
// MID   | forwarding body words, merging residual from previous word
// LST   | emitting the final residual-only word
// DRP   | discarding the rest of a dropped packet
module header_adder_var #(
  parameter int DATA_WIDTH = 128,
  parameter int HDR_WIDTH  = 64,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_BYTES  = HDR_WIDTH / 8,
  parameter int LEN_WIDTH  = $clog2(HDR_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [HDR_WIDTH-1:0]  header,
  input  logic [LEN_WIDTH-1:0]  header_len,
  input  logic                  drop,
  input  logic                  header_valid,
  output logic                  header_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [STRB_WIDTH-1:0] m_axis_tkeep,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int KSH_W = $clog2(STRB_WIDTH + 1);
  localparam int SH_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MID, LST, DRP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [STRB_WIDTH-1:0] rk_q, rk_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic [LEN_WIDTH-1:0]  len_cur;
  logic [KSH_W-1:0]      lsh_k, rsh_k;
  logic [SH_W-1:0]       lsh_b, rsh_b;
  logic [DATA_WIDTH-1:0] hdr_ext, hdr_mask, sh_data, res_data, low_data;
  logic [STRB_WIDTH-1:0] sh_keep, res_keep, low_keep;

  logic                  s_rdy, m_vld, h_rdy, m_last;
  logic [DATA_WIDTH-1:0] m_data;
  logic [STRB_WIDTH-1:0] m_keep;

  // Shift amounts: left by L bytes for the incoming word, right by
  // (STRB_WIDTH - L) bytes to capture the bytes that spill into the next
  // output word. A shift of a full word width yields zero, which covers
  // both L = 0 (no residual) and L = STRB_WIDTH (no incoming bytes kept).
  assign len_cur = (state_q == IDLE) ? header_len : len_q;
  assign lsh_k   = KSH_W'(len_cur);
  assign rsh_k   = KSH_W'(STRB_WIDTH) - lsh_k;
  assign lsh_b   = SH_W'(lsh_k) << 3;
  assign rsh_b   = SH_W'(rsh_k) << 3;

  assign hdr_ext  = DATA_WIDTH'(header);
  assign hdr_mask = ~({DATA_WIDTH{1'b1}} << lsh_b);
  assign sh_data  = s_axis_tdata << lsh_b;
  assign sh_keep  = s_axis_tkeep << lsh_k;
  assign res_data = s_axis_tdata >> rsh_b;
  assign res_keep = s_axis_tkeep >> rsh_k;

  // Low bytes of the output word: header bytes on the first word,
  // otherwise the residual carried over from the previous input word.
  assign low_data = (state_q == IDLE) ? (hdr_ext & hdr_mask) : rd_q;
  assign low_keep = (state_q == IDLE) ? ~({STRB_WIDTH{1'b1}} << lsh_k) : rk_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    rk_d    = rk_q;
    dest_d  = dest_q;
    user_d  = user_q;
    s_rdy   = 1'b0;
    m_vld   = 1'b0;
    h_rdy   = 1'b0;
    m_last  = 1'b0;
    m_data  = sh_data | low_data;
    m_keep  = sh_keep | low_keep;

    case (state_q)
      IDLE: begin
        if (header_valid) begin
          if (drop) begin
            s_rdy = 1'b1;
            h_rdy = s_axis_tvalid;
            if (s_axis_tvalid && !s_axis_tlast) state_d = DRP;
          end else begin
            m_vld  = s_axis_tvalid;
            s_rdy  = m_axis_tready;
            h_rdy  = s_axis_tvalid & m_axis_tready;
            m_last = s_axis_tlast & (res_keep == '0);
            if (s_axis_tvalid && m_axis_tready) begin
              len_d  = header_len;
              dest_d = s_axis_tdest;
              user_d = s_axis_tuser;
              rd_d   = res_data;
              rk_d   = res_keep;
              if (!s_axis_tlast)         state_d = MID;
              else if (res_keep != '0)   state_d = LST;
              else                       state_d = IDLE;
            end
          end
        end
      end
      MID: begin
        m_vld  = s_axis_tvalid;
        s_rdy  = m_axis_tready;
        m_last = s_axis_tlast & (res_keep == '0);
        if (s_axis_tvalid && m_axis_tready) begin
          rd_d = res_data;
          rk_d = res_keep;
          if (s_axis_tlast) state_d = (res_keep != '0) ? LST : IDLE;
        end
      end
      LST: begin
        m_vld  = 1'b1;
        m_data = rd_q;
        m_keep = rk_q;
        m_last = 1'b1;
        if (m_axis_tready) state_d = IDLE;
      end
      DRP: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      rd_q    <= '0;
      rk_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      rk_q    <= rk_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign s_axis_tready = s_rdy & ~rst;
  assign m_axis_tvalid = m_vld & ~rst;
  assign header_ready  = h_rdy & ~rst;
  assign m_axis_tdata  = m_data;
  assign m_axis_tkeep  = m_keep;
  assign m_axis_tlast  = m_last;
  assign m_axis_tdest  = (state_q == IDLE) ? s_axis_tdest : dest_q;
  assign m_axis_tuser  = (state_q == IDLE) ? s_axis_tuser : user_q;

endmodule
